// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with majority-vote bit recovery,
// per-frame error tags, FWFT receive FIFO and RTS flow control.
module uart_rx_fifo #(
  parameter int DATA_BITS     = 8,
  parameter int SYS_CLK_FREQ  = 125000000,
  parameter int BAUD_RATE     = 115200,
  parameter int OVERSAMPLE    = 16,
  parameter int PARITY_ENABLE = 0,
  parameter int PARITY_TYPE   = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 16,
  parameter int RTS_THRESHOLD = 12
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              RX,
  output logic [DATA_BITS-1:0]              m_data,
  output logic [1:0]                        m_err,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              RTS,
  output logic                              overflow,
  input  logic                              clr_overflow
);

  localparam int DIV = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam int EW  = DATA_BITS + 2;

  localparam logic [DCW-1:0] D_END = DCW'(DIV - 1);
  localparam logic [SCW-1:0] S_LO  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] S_MID = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] S_HI  = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [SCW-1:0] S_END = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] B_END = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] B_STP = BCW'(STOP_BITS - 1);
  localparam logic [LW-1:0]  L_FUL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]  L_THR = LW'(RTS_THRESHOLD);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK_WAIT
  } state_t;

  state_t               state, state_n;
  logic                 rx_m, rx_s;
  logic [DCW-1:0]       dc;
  logic                 tick, restart;
  logic [SCW-1:0]       sc, sc_n;
  logic [BCW-1:0]       bc, bc_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic [1:0]           smp, smp_n;
  logic                 ferr, fe_n;
  logic                 perr, pe_n;
  logic                 push, vt, bit_end, vote;
  logic [EW-1:0]        push_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  assign tick = (dc == D_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              dc <= '0;
    else if (restart || tick) dc <= '0;
    else                     dc <= dc + 1'b1;
  end

  assign vt      = tick && (sc == S_HI);
  assign bit_end = tick && (sc == S_END);
  assign vote    = (smp[1] & smp[0]) | (smp[1] & rx_s)
                 | (smp[0] & rx_s);

  always_comb begin
    state_n = state;
    sc_n    = sc;
    bc_n    = bc;
    sh_n    = sh;
    smp_n   = smp;
    fe_n    = ferr;
    pe_n    = perr;
    push    = 1'b0;
    restart = 1'b0;
    if (tick && state != IDLE && state != BREAK_WAIT) begin
      sc_n = sc + 1'b1;
      if (sc == S_LO || sc == S_MID)
        smp_n = {smp[0], rx_s};
    end
    unique case (state)
      IDLE: begin
        if (tick && !rx_s) begin
          state_n = START;
          sc_n    = '0;
          bc_n    = '0;
          fe_n    = 1'b0;
          pe_n    = 1'b0;
          restart = 1'b1;
        end
      end
      START: begin
        if (vt && vote) begin
          state_n = IDLE;
        end else if (bit_end) begin
          state_n = DATA;
          sc_n    = '0;
        end
      end
      DATA: begin
        if (vt)
          sh_n = {vote, sh[DATA_BITS-1:1]};
        if (bit_end) begin
          sc_n = '0;
          if (bc == B_END) begin
            bc_n    = '0;
            state_n = (PARITY_ENABLE != 0) ? PARITY : STOP;
          end else begin
            bc_n = bc + 1'b1;
          end
        end
      end
      PARITY: begin
        if (vt)
          pe_n = ((^{sh, vote}) == (PARITY_TYPE != 0));
        if (bit_end) begin
          state_n = STOP;
          sc_n    = '0;
        end
      end
      STOP: begin
        if (vt) begin
          fe_n = ferr | ~vote;
          // the frame is committed mid-bit so back-to-back
          // frames never lose their start edge
          if (bc == B_STP) begin
            push    = 1'b1;
            state_n = fe_n ? BREAK_WAIT : IDLE;
          end
        end else if (bit_end) begin
          sc_n = '0;
          bc_n = bc + 1'b1;
        end
      end
      BREAK_WAIT: begin
        if (tick && rx_s)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sc    <= '0;
      bc    <= '0;
      sh    <= '0;
      smp   <= '0;
      ferr  <= 1'b0;
      perr  <= 1'b0;
    end else begin
      state <= state_n;
      sc    <= sc_n;
      bc    <= bc_n;
      sh    <= sh_n;
      smp   <= smp_n;
      ferr  <= fe_n;
      perr  <= pe_n;
    end
  end

  assign push_w = {perr, fe_n, sh};

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [LW-1:0] cnt;
  logic          full, pop, wr;
  logic [EW-1:0] head;

  assign full = (cnt == L_FUL);
  assign pop  = m_valid && m_ready;
  assign wr   = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr)
      mem[wp] <= push_w;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
      RTS      <= 1'b1;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + LW'(wr) - LW'(pop);
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_overflow)    overflow <= 1'b0;
      RTS <= (cnt < L_THR);
    end
  end

  assign head    = mem[rp];
  assign m_valid = (cnt != '0);
  assign m_data  = m_valid ? head[DATA_BITS-1:0] : '0;
  assign m_err   = m_valid ? head[EW-1 -: 2] : 2'b00;
  assign level   = cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: default-rate, fast-rate
// and parity-enabled instances driven by hand-built frames.
module tb_uart_rx_fifo;

  localparam int FAST = 7372800;
  localparam int BP0  = 1072;
  localparam int BP1  = 64;

  logic clk = 1'b0;
  logic reset;
  logic rx0, rx1, rx2;
  logic rdy0, rdy1, rdy2;
  logic clr0, clr1, clr2;
  logic [7:0] d0, d1, d2;
  logic [1:0] e0, e1, e2;
  logic v0, v1, v2;
  logic [4:0] l0, l1, l2;
  logic rts0, rts1, rts2;
  logic ov0, ov1, ov2;

  int errors = 0;
  int checks = 0;
  logic rts0_low = 1'b0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] q2[$];

  always #5 clk = ~clk;

  uart_rx_fifo dut0 (
    .clk(clk), .reset(reset), .RX(rx0),
    .m_data(d0), .m_err(e0), .m_valid(v0), .m_ready(rdy0),
    .level(l0), .RTS(rts0), .overflow(ov0),
    .clr_overflow(clr0)
  );

  uart_rx_fifo #(.SYS_CLK_FREQ(FAST)) dut1 (
    .clk(clk), .reset(reset), .RX(rx1),
    .m_data(d1), .m_err(e1), .m_valid(v1), .m_ready(rdy1),
    .level(l1), .RTS(rts1), .overflow(ov1),
    .clr_overflow(clr1)
  );

  uart_rx_fifo #(
    .SYS_CLK_FREQ(FAST), .PARITY_ENABLE(1), .PARITY_TYPE(1)
  ) dutp (
    .clk(clk), .reset(reset), .RX(rx2),
    .m_data(d2), .m_err(e2), .m_valid(v2), .m_ready(rdy2),
    .level(l2), .RTS(rts2), .overflow(ov2),
    .clr_overflow(clr2)
  );

  always @(posedge clk) begin
    if (v0 && rdy0) q0.push_back({e0, d0});
    if (v1 && rdy1) q1.push_back({e1, d1});
    if (v2 && rdy2) q2.push_back({e2, d2});
    if (reset && !rts0) rts0_low = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic set_rx(input int u, input logic b);
    case (u)
      0: rx0 = b;
      1: rx1 = b;
      default: rx2 = b;
    endcase
  endtask

  task automatic send(input int u, input int bp,
                      input logic [11:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(u, f[i]);
      repeat (bp) @(negedge clk);
    end
    set_rx(u, 1'b1);
  endtask

  function automatic logic [11:0] fr8(input logic [7:0] d,
                                      input logic stp);
    return {2'b11, stp, d, 1'b0};
  endfunction

  function automatic logic [11:0] frp(input logic [7:0] d,
                                      input logic p);
    return {2'b11, p, d, 1'b0};
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    {rx0, rx1, rx2} = 3'b111;
    {rdy0, rdy1, rdy2} = 3'b111;
    {clr0, clr1, clr2} = 3'b000;
    repeat (4) @(negedge clk);
    chk("rst_data", d1, 0);
    chk("rst_err", e1, 0);
    chk("rst_valid", v1, 0);
    chk("rst_level", l1, 0);
    chk("rst_ovf", ov1, 0);
    chk("rst_rts", rts1, 1);
    chk("rst_rts0", rts0, 1);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // default rate, single frame
    send(0, BP0, fr8(8'hD9, 1'b1), 10);
    repeat (100) @(negedge clk);
    chk("t1_count", q0.size(), 1);
    if (q0.size() > 0) chk("t1_word", q0[0], {2'b00, 8'hD9});
    chk("t1_level", l0, 0);
    chk("t1_rts", rts0_low, 0);

    // false start, then a good frame
    rx0 = 1'b0;
    repeat (200) @(negedge clk);
    rx0 = 1'b1;
    repeat (1200) @(negedge clk);
    chk("t2_nopush", q0.size(), 1);
    chk("t2_valid", v0, 0);
    send(0, BP0, fr8(8'h55, 1'b1), 10);
    repeat (100) @(negedge clk);
    chk("t2_count", q0.size(), 2);
    if (q0.size() > 1) chk("t2_word", q0[1], {2'b00, 8'h55});

    // even parity
    send(2, BP1, frp(8'h07, 1'b1), 11);
    send(2, BP1, frp(8'h07, 1'b0), 11);
    repeat (20) @(negedge clk);
    chk("t3_count", q2.size(), 2);
    if (q2.size() > 1) begin
      chk("t3_good", q2[0], {2'b00, 8'h07});
      chk("t3_bad", q2[1], {2'b10, 8'h07});
    end

    // framing error followed by a held break
    send(1, BP1, fr8(8'h00, 1'b0), 10);
    rx1 = 1'b0;
    repeat (20 * BP1) @(negedge clk);
    rx1 = 1'b1;
    repeat (2 * BP1) @(negedge clk);
    chk("t4_count", q1.size(), 1);
    if (q1.size() > 0) chk("t4_word", q1[0], {2'b01, 8'h00});
    send(1, BP1, fr8(8'hA3, 1'b1), 10);
    repeat (20) @(negedge clk);
    chk("t4_count2", q1.size(), 2);
    if (q1.size() > 1) chk("t4_next", q1[1], {2'b00, 8'hA3});

    // fill past full with consumer stalled
    q1.delete();
    rdy1 = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      send(1, BP1, fr8(8'(i), 1'b1), 10);
      if (i == 11) begin
        chk("t5_lvl11", l1, 11);
        chk("t5_rts11", rts1, 1);
      end
      if (i == 12) begin
        chk("t5_lvl12", l1, 12);
        chk("t5_rts12", rts1, 0);
      end
    end
    repeat (4) @(negedge clk);
    chk("t5_full", l1, 16);
    chk("t5_ovf", ov1, 1);
    chk("t5_valid", v1, 1);
    chk("t5_head", {e1, d1}, {2'b00, 8'h01});
    rdy1 = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_dr12", l1, 12);
    chk("t5_drrts0", rts1, 0);
    @(negedge clk);
    rdy1 = 1'b0;
    @(negedge clk);
    chk("t5_dr11", l1, 11);
    chk("t5_drrts1", rts1, 1);
    rdy1 = 1'b1;
    repeat (14) @(negedge clk);
    chk("t5_empty", l1, 0);
    chk("t5_evalid", v1, 0);
    chk("t5_pops", q1.size(), 16);
    for (int i = 0; i < q1.size() && i < 16; i++)
      chk("t5_order", q1[i], {2'b00, 8'(i + 1)});
    chk("t5_ovfkeep", ov1, 1);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    chk("t5_clr", ov1, 0);

    // reset in the middle of data bit 4
    rdy1 = 1'b0;
    send(1, BP1, fr8(8'h11, 1'b1), 10);
    chk("t6_pre", l1, 1);
    send(1, BP1, 12'h000, 5);
    rx1 = 1'b0;
    repeat (BP1 / 2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_level", l1, 0);
    chk("t6_valid", v1, 0);
    chk("t6_data", d1, 0);
    chk("t6_err", e1, 0);
    chk("t6_rts", rts1, 1);
    chk("t6_ovf", ov1, 0);
    repeat (3) @(negedge clk);
    rx1 = 1'b1;
    reset = 1'b1;
    repeat (3 * BP1) @(negedge clk);
    q1.delete();
    rdy1 = 1'b1;
    send(1, BP1, fr8(8'h3C, 1'b1), 10);
    repeat (20) @(negedge clk);
    chk("t6_count", q1.size(), 1);
    if (q1.size() > 0) chk("t6_word", q1[0], {2'b00, 8'h3C});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
